// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e   : controller states (IDLE, RUN, DONE), 2-bit encoding
//   cnt_width : iteration counter width for a given operand width (clog2)
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter must hold 0..WIDTH-1; clamp to one bit for tiny widths.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and result bus of the sequential divider.
//   master : ALU control side (drives start and operands, reads results)
//   slave  : divider side
interface seq_restoring_divider_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sub_stage.sv
// Combinational WIDTH-bit subtractor: difference = minuend - subtrahend.
// Built as a ripple of full-adder cells with the subtrahend inverted and
// carry-in = 1; borrow is the inverted final carry.
//   minuend, subtrahend : operands
//   difference          : result modulo 2**WIDTH
//   borrow              : 1 when subtrahend > minuend
module div_sub_stage #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);
    always_comb begin
        logic carry;
        logic b_inv;
        carry      = 1'b1;
        b_inv      = 1'b0;
        difference = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b_inv         = ~subtrahend[i];
            difference[i] = minuend[i] ^ b_inv ^ carry;
            carry         = (minuend[i] & b_inv) | (carry & (minuend[i] ^ b_inv));
        end
        borrow = ~carry;
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : start/operands in; busy, done pulse, quotient, remainder,
//              div_by_zero out (results held until the next accepted start)
module seq_restoring_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;     // partial remainder
    logic [WIDTH-1:0] shreg_q, shreg_d;   // dividend bits out, quotient bits in
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   next_prem;
    logic             borrow;
    logic             unused_prem_msb;

    // The partial remainder is always < divisor, so its MSB is zero and
    // dropping it in the shift loses nothing.
    assign shifted         = {prem_q[WIDTH-1:0], shreg_q[WIDTH-1]};
    assign unused_prem_msb = prem_q[WIDTH];

    div_sub_stage #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, dvsr_q}),
        .difference (trial),
        .borrow     (borrow)
    );

    // Restore on borrow, otherwise keep the trial difference.
    assign next_prem = borrow ? shifted : trial;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        shreg_d = shreg_q;
        dvsr_d  = dvsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        shreg_d = bus.dividend;
                        dvsr_d  = bus.divisor;
                        prem_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                prem_d  = next_prem;
                shreg_d = {shreg_q[WIDTH-2:0], ~borrow};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quo_d   = shreg_d;
                    rem_d   = next_prem[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            shreg_q <= shreg_d;
            dvsr_q  <= dvsr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule
